cover_toggle_drain: RTL and testbench
=====================================

# cover_toggle_drain

Coverage-event drain controller for the toggle-coverage path. It captures a wide per-cycle toggle hit vector into a sticky pending map and reports each bit only on its first hit. Pending hits are serialized lowest index first, one global cover index per transfer, over a valid/ready port. This lets a single downstream reporter (DPI bridge, trace FIFO or counter RAM) be shared by WIDTH hit sources instead of WIDTH parallel calls per cycle.

## Interface
- WIDTH, 40, number of toggle hit bits handled by this instance.
- COVER_INDEX, 0, global cover index of bit 0; bit i reports COVER_INDEX + i.
- COVER_TOTAL, 10906, total cover points in the design; used only for the index range check in simulation.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid  input  WIDTH  per-bit toggle hit for the current cycle.
- enable  input  1  capture enable; when 0, valid is ignored and draining continues.
- clear  input  1  synchronous flush of the covered and pending maps.
- out_valid  output  1  out_index holds a report.
- out_ready  input  1  consumer accepts the report.
- out_index  output  64  global cover index, COVER_INDEX + bit.
- covered_count  output  $clog2(WIDTH+1)  number of bits reported so far.
- all_covered  output  1  asserted when covered_count == WIDTH.

## Operation
- State: pending[WIDTH], covered[WIDTH], cur[$clog2(WIDTH)], FSM {IDLE, SEND}.
- Capture: each edge with enable=1, clear=0: pending |= valid & ~covered. Bits already pending or covered are not re-queued, so each bit is reported at most once between clears.
- Selection: sel = lowest set bit of the registered pending & ~covered, excluding cur while in SEND. Same-cycle valid is never used for selection.
- IDLE: if the selection mask is non-zero, load cur = sel and out_index = COVER_INDEX + sel, then go to SEND. Otherwise stay in IDLE.
- SEND: out_valid=1. out_index and cur stay stable until the handshake.
- Handshake (out_valid & out_ready) at an edge: clear pending[cur], set covered[cur], increment covered_count.
  - If another candidate exists, load it and stay in SEND (back-to-back, one report per cycle).
  - Otherwise go to IDLE.
- clear=1 at an edge overrides capture and handshake bookkeeping:
  - pending, covered and covered_count go to 0, FSM goes to IDLE, out_valid goes to 0.
  - A handshake in the clear cycle is consumed by the consumer but not recorded.
  - valid in the clear cycle is dropped.
- covered_count saturates naturally at WIDTH because each bit is set at most once. all_covered = (covered_count == WIDTH).
- Simulation-only check: error if COVER_INDEX + WIDTH > COVER_TOTAL.

## Timing
- Reset (reset=0, async): pending=0, covered=0, covered_count=0, cur=0, out_index=0, out_valid=0, all_covered=0, FSM=IDLE.
- Hit-to-report latency, from IDLE with no backlog: valid sampled at edge E0 sets pending; out_valid rises after E1. Two edges.
- Throughput: one report per cycle while out_ready=1 and the backlog is non-empty.
- Backpressure: out_valid must not drop and out_index must not change while out_ready=0.
- A hit on bit cur while it is being presented is absorbed; there is no duplicate report.
- A hit on a lower index than cur arriving during SEND is reported after cur. There is no preemption.
- Reset deasserted mid-transfer: all state is lost and no report is replayed.

## Test plan
- Single hit: valid=1<<5, COVER_INDEX=100, out_ready=1 -> out_valid high two edges later with out_index=105 for one cycle; covered_count=1.
- Burst ordering: valid=0x80_0000_0009 in one cycle, out_ready=1 -> out_index 100, 103, 139 on consecutive cycles; covered_count=3.
- Dedup: bit 2 hit on ten consecutive cycles, with out_ready held 0 for 4 cycles then 1 -> exactly one report of 102; out_index stable during the stall.
- Full coverage: all 40 bits hit once -> 40 reports in ascending order; all_covered=1 after the 40th handshake; further hits produce no reports.
- Clear mid-drain: 3 bits pending, clear asserted during SEND -> out_valid=0 next cycle, covered_count=0; re-hitting the same bits reports them again.
- Async reset during SEND: reset pulsed low between edges -> out_valid, out_index and covered_count go to 0 immediately; enable=0 after reset -> no captures.

Source files
------------

// File: rtl/cover_toggle_drain_if.sv
// Report port of the toggle-coverage drain: one global cover index per
// valid/ready transfer.
interface cover_toggle_drain_if;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_index;

    modport master (
        output out_valid,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/cover_toggle_drain.sv
// Captures first hits of a wide toggle vector into a sticky pending map and
// drains them, lowest index first, as global cover indices over a valid/ready port.
module cover_toggle_drain #(
    parameter int WIDTH       = 40,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 10906
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       enable,
    input  logic                       clear,
    cover_toggle_drain_if.master       report,
    output logic [$clog2(WIDTH+1)-1:0] covered_count,
    output logic                       all_covered
);
    localparam int CUR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_reg,   state_next;
    logic [WIDTH-1:0]  pending_reg, pending_next;
    logic [WIDTH-1:0]  covered_reg, covered_next;
    logic [CUR_W-1:0]  cur_reg,     cur_next;
    logic [63:0]       index_reg,   index_next;
    logic [CNT_W-1:0]  count_reg,   count_next;

    logic [WIDTH-1:0]  cur_onehot;
    logic [WIDTH-1:0]  cand;
    logic [CUR_W-1:0]  sel;
    logic              cand_any;
    logic              handshake;

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
        $error("cover_toggle_drain: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end

    // The bit being presented is not a candidate until its handshake retires it.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cand
        assign cur_onehot[gi] = (cur_reg == CUR_W'(gi));
        assign cand[gi]       = pending_reg[gi] & ~covered_reg[gi]
                              & ~((state_reg == SEND) & cur_onehot[gi]);
    end

    assign cand_any  = |cand;
    assign handshake = (state_reg == SEND) & report.out_ready;

    always_comb begin
        sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = CUR_W'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        covered_next = covered_reg;
        cur_next     = cur_reg;
        index_next   = index_reg;
        count_next   = count_reg;

        if (enable) begin
            pending_next = pending_reg | (valid & ~covered_reg);
        end

        if (state_reg == IDLE) begin
            if (cand_any) begin
                cur_next   = sel;
                index_next = 64'(COVER_INDEX) + 64'(sel);
                state_next = SEND;
            end
        end else if (handshake) begin
            // Retiring after capture absorbs a same-cycle re-hit of cur.
            pending_next = pending_next & ~cur_onehot;
            covered_next = covered_reg | cur_onehot;
            count_next   = count_reg + CNT_W'(1);
            if (cand_any) begin
                cur_next   = sel;
                index_next = 64'(COVER_INDEX) + 64'(sel);
            end else begin
                state_next = IDLE;
            end
        end

        if (clear) begin
            pending_next = '0;
            covered_next = '0;
            count_next   = '0;
            state_next   = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            covered_reg <= '0;
            cur_reg     <= '0;
            index_reg   <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            covered_reg <= covered_next;
            cur_reg     <= cur_next;
            index_reg   <= index_next;
            count_reg   <= count_next;
        end
    end

    assign report.out_valid = (state_reg == SEND);
    assign report.out_index = index_reg;
    assign covered_count    = count_reg;
    assign all_covered      = (count_reg == CNT_W'(WIDTH));
endmodule

// File: tb/tb_cover_toggle_drain.sv
// Directed bench for cover_toggle_drain with COVER_INDEX=100, WIDTH=40.
module tb_cover_toggle_drain;
    localparam int WIDTH = 40;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] valid;
    logic             enable;
    logic             clear;
    logic [5:0]       covered_count;
    logic             all_covered;

    int total = 0;
    int bad   = 0;

    cover_toggle_drain_if rpt ();

    cover_toggle_drain #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (100),
        .COVER_TOTAL (10906)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .enable        (enable),
        .clear         (clear),
        .report        (rpt.master),
        .covered_count (covered_count),
        .all_covered   (all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b0;
        valid         = '0;
        enable        = 1'b0;
        clear         = 1'b0;
        rpt.out_ready = 1'b0;
        #3;
        chk("reset_valid", 64'(rpt.out_valid), 0);
        chk("reset_index", rpt.out_index, 0);
        chk("reset_count", 64'(covered_count), 0);
        chk("reset_all", 64'(all_covered), 0);
        step();
        reset  = 1'b1;
        enable = 1'b1;
        rpt.out_ready = 1'b1;
        step();

        // single hit on bit 5: two-edge latency, one-cycle report
        valid = 40'd1 << 5;
        step();
        valid = '0;
        chk("single_e0_valid", 64'(rpt.out_valid), 0);
        step();
        chk("single_e1_valid", 64'(rpt.out_valid), 1);
        chk("single_e1_index", rpt.out_index, 105);
        step();
        chk("single_done_valid", 64'(rpt.out_valid), 0);
        chk("single_count", 64'(covered_count), 1);
        $display("txn single: index=105 count=%0d", covered_count);

        // burst ordering after a flush
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_count", 64'(covered_count), 0);
        valid = 40'h80_0000_0009;
        step();
        valid = '0;
        step();
        chk("burst_idx0", rpt.out_index, 100);
        chk("burst_v0", 64'(rpt.out_valid), 1);
        step();
        chk("burst_idx1", rpt.out_index, 103);
        chk("burst_v1", 64'(rpt.out_valid), 1);
        step();
        chk("burst_idx2", rpt.out_index, 139);
        chk("burst_v2", 64'(rpt.out_valid), 1);
        step();
        chk("burst_end_valid", 64'(rpt.out_valid), 0);
        chk("burst_count", 64'(covered_count), 3);
        $display("txn burst: indices 100,103,139 count=%0d", covered_count);

        // dedup: bit 2 hit for ten cycles, four stalled cycles first
        rpt.out_ready = 1'b0;
        valid = 40'd1 << 2;
        step();
        chk("dedup_e0_valid", 64'(rpt.out_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("dedup_stall_valid", 64'(rpt.out_valid), 1);
            chk("dedup_stall_index", rpt.out_index, 102);
        end
        rpt.out_ready = 1'b1;
        step();
        chk("dedup_hs_valid", 64'(rpt.out_valid), 0);
        chk("dedup_hs_count", 64'(covered_count), 4);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("dedup_rehit_valid", 64'(rpt.out_valid), 0);
        end
        valid = '0;
        step();
        chk("dedup_final_count", 64'(covered_count), 4);
        $display("txn dedup: single report 102 count=%0d", covered_count);

        // no preemption: lower index arriving during a stalled SEND waits
        clear = 1'b1;
        step();
        clear = 1'b0;
        rpt.out_ready = 1'b0;
        valid = 40'd1 << 10;
        step();
        valid = '0;
        step();
        chk("nopre_first", rpt.out_index, 110);
        valid = 40'd1 << 4;
        step();
        valid = '0;
        chk("nopre_hold_index", rpt.out_index, 110);
        chk("nopre_hold_valid", 64'(rpt.out_valid), 1);
        rpt.out_ready = 1'b1;
        step();
        chk("nopre_second", rpt.out_index, 104);
        chk("nopre_second_valid", 64'(rpt.out_valid), 1);
        step();
        chk("nopre_end_valid", 64'(rpt.out_valid), 0);
        chk("nopre_count", 64'(covered_count), 2);
        $display("txn nopreempt: 110 then 104");

        // full coverage: all bits in ascending order, then saturation
        clear = 1'b1;
        step();
        clear = 1'b0;
        valid = '1;
        step();
        valid = '0;
        for (int i = 0; i < WIDTH; i++) begin
            step();
            chk("full_valid", 64'(rpt.out_valid), 1);
            chk("full_index", rpt.out_index, 64'(100 + i));
        end
        chk("full_not_yet_all", 64'(all_covered), 0);
        step();
        chk("full_end_valid", 64'(rpt.out_valid), 0);
        chk("full_count", 64'(covered_count), 40);
        chk("full_all", 64'(all_covered), 1);
        valid = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_rehit_valid", 64'(rpt.out_valid), 0);
        end
        valid = '0;
        chk("full_rehit_count", 64'(covered_count), 40);
        $display("txn full: 40 reports, all_covered=%0d", all_covered);

        // clear during SEND, handshake in the clear cycle not recorded
        clear = 1'b1;
        step();
        clear = 1'b0;
        rpt.out_ready = 1'b0;
        valid = 40'hE;
        step();
        valid = '0;
        step();
        chk("clr_send_index", rpt.out_index, 101);
        clear = 1'b1;
        rpt.out_ready = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_valid", 64'(rpt.out_valid), 0);
        chk("clr_count", 64'(covered_count), 0);
        step();
        chk("clr_idle_valid", 64'(rpt.out_valid), 0);
        valid = 40'hE;
        step();
        valid = '0;
        step();
        chk("clr_re_idx0", rpt.out_index, 101);
        step();
        chk("clr_re_idx1", rpt.out_index, 102);
        step();
        chk("clr_re_idx2", rpt.out_index, 103);
        step();
        chk("clr_re_count", 64'(covered_count), 3);
        $display("txn clear: re-reported 101,102,103");

        // async reset between edges while presenting
        rpt.out_ready = 1'b0;
        valid = 40'd1 << 7;
        step();
        valid = '0;
        step();
        chk("arst_pre_index", rpt.out_index, 107);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(rpt.out_valid), 0);
        chk("arst_index", rpt.out_index, 0);
        chk("arst_count", 64'(covered_count), 0);
        reset  = 1'b1;
        enable = 1'b0;
        rpt.out_ready = 1'b1;
        valid = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("noen_valid", 64'(rpt.out_valid), 0);
        end
        chk("noen_count", 64'(covered_count), 0);
        valid = '0;
        $display("txn async_reset: state cleared, no captures with enable=0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
